// File: rtl/edge_det_matched.sv
// Boxcar step/edge detector for the ADC sample stream.
// A matched filter (newest half-window sum minus previous half-window sum)
// feeds a four-state detector with strict threshold crossing, holdoff dead
// time and hysteresis re-arm. It also keeps a sample-index timestamp of the
// last event and saturating rise/fall event counters.
//
// Pipeline: a sample accepted at edge k is captured at k, folded into conv
// at k+1 and judged at k+2, so a pulse is high in the cycle after k+2
// regardless of gaps in sample_valid.

module edge_det_matched #(
    parameter int DATA_W    = 14,
    parameter int LOG2_HALF = 6,
    parameter int HOLDOFF_W = 16,
    parameter int TS_W      = 32,
    parameter int CNT_W     = 16,
    localparam int SUM_W    = DATA_W + LOG2_HALF + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 sample_valid,
    input  logic [DATA_W-1:0]    sample,
    input  logic [SUM_W-2:0]     thresh,
    input  logic [SUM_W-2:0]     rearm,
    input  logic [HOLDOFF_W-1:0] holdoff,
    output logic [SUM_W-1:0]     conv,
    output logic                 conv_valid,
    output logic                 edge_rise,
    output logic                 edge_fall,
    output logic [TS_W-1:0]      event_ts,
    output logic [CNT_W-1:0]     rise_count,
    output logic [CNT_W-1:0]     fall_count,
    output logic [1:0]           det_state
);

    localparam int HALF   = 2 ** LOG2_HALF;
    localparam int N      = 2 * HALF;
    localparam int FILL_W = LOG2_HALF + 2;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ARMED      = 2'd1,
        ST_HOLDOFF    = 2'd2,
        ST_WAIT_REARM = 2'd3
    } state_t;

    // Saturating increment for the event counters: stick at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Capture stage
    logic                acc_r;
    logic [DATA_W-1:0]   smp_r;
    logic [TS_W-1:0]     smp_idx_r;
    logic [TS_W-1:0]     sample_idx_r;

    // Filter stage
    logic [DATA_W-1:0]         dl_r [N];
    logic signed [SUM_W-1:0]   conv_r;
    logic signed [SUM_W-1:0]   conv_nxt_s;
    logic signed [SUM_W-1:0]   s_new_s;
    logic signed [SUM_W-1:0]   d_half_s;
    logic signed [SUM_W-1:0]   d_full_s;
    logic [TS_W-1:0]           conv_idx_r;
    logic                      upd_r;
    logic [FILL_W-1:0]         fill_r;
    logic                      conv_valid_r;

    // Detector stage
    state_t                    state_r;
    logic [HOLDOFF_W-1:0]      ho_cnt_r;
    logic                      edge_rise_r;
    logic                      edge_fall_r;
    logic [TS_W-1:0]           event_ts_r;
    logic [CNT_W-1:0]          rise_cnt_r;
    logic [CNT_W-1:0]          fall_cnt_r;
    logic signed [SUM_W-1:0]   thr_s;
    logic signed [SUM_W-1:0]   rr_s;
    logic                      above_s;
    logic                      below_s;
    logic                      in_band_s;

    // Register accepted samples and stamp each with its sample index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r        <= 1'b0;
            smp_r        <= '0;
            smp_idx_r    <= '0;
            sample_idx_r <= '0;
        end else if (!enable) begin
            acc_r        <= 1'b0;
            smp_r        <= '0;
        end else begin
            acc_r <= sample_valid;
            if (sample_valid) begin
                smp_r        <= sample;
                smp_idx_r    <= sample_idx_r;
                sample_idx_r <= sample_idx_r + TS_W'(1);
            end
        end
    end

    // Recursive boxcar update: add newest, move d[HALF] across halves, drop d[N].
    always_comb begin
        s_new_s    = $signed({{(SUM_W-DATA_W){1'b0}}, smp_r});
        d_half_s   = $signed({{(SUM_W-DATA_W){1'b0}}, dl_r[HALF-1]});
        d_full_s   = $signed({{(SUM_W-DATA_W){1'b0}}, dl_r[N-1]});
        conv_nxt_s = conv_r + s_new_s - (d_half_s <<< 1) + d_full_s;
    end

    // Delay line, filter accumulator and window-fill tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                dl_r[i] <= '0;
            end
            conv_r       <= '0;
            conv_idx_r   <= '0;
            upd_r        <= 1'b0;
            fill_r       <= '0;
            conv_valid_r <= 1'b0;
        end else if (!enable) begin
            for (int i = 0; i < N; i++) begin
                dl_r[i] <= '0;
            end
            conv_r       <= '0;
            upd_r        <= 1'b0;
            fill_r       <= '0;
            conv_valid_r <= 1'b0;
        end else begin
            upd_r <= acc_r;
            if (acc_r) begin
                conv_r     <= conv_nxt_s;
                conv_idx_r <= smp_idx_r;
                dl_r[0]    <= smp_r;
                for (int i = 1; i < N; i++) begin
                    dl_r[i] <= dl_r[i-1];
                end
                if (fill_r != FILL_W'(N)) begin
                    fill_r <= fill_r + FILL_W'(1);
                end
                if (fill_r >= FILL_W'(N - 1)) begin
                    conv_valid_r <= 1'b1;
                end
            end
        end
    end

    // Threshold and re-arm band comparisons on the registered filter output.
    always_comb begin
        thr_s     = $signed({1'b0, thresh});
        rr_s      = $signed({1'b0, rearm});
        above_s   = (conv_r > thr_s);
        below_s   = (conv_r < -thr_s);
        in_band_s = (conv_r >= -rr_s) && (conv_r <= rr_s);
    end

    // Detector FSM with registered pulses, timestamp and event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            ho_cnt_r    <= '0;
            edge_rise_r <= 1'b0;
            edge_fall_r <= 1'b0;
            event_ts_r  <= '0;
            rise_cnt_r  <= '0;
            fall_cnt_r  <= '0;
        end else if (!enable) begin
            state_r     <= ST_IDLE;
            ho_cnt_r    <= '0;
            edge_rise_r <= 1'b0;
            edge_fall_r <= 1'b0;
        end else begin
            edge_rise_r <= 1'b0;
            edge_fall_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (conv_valid_r) begin
                        state_r <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (upd_r && above_s) begin
                        edge_rise_r <= 1'b1;
                        rise_cnt_r  <= sat_inc(rise_cnt_r);
                        event_ts_r  <= conv_idx_r;
                        ho_cnt_r    <= '0;
                        state_r     <= ST_HOLDOFF;
                    end else if (upd_r && below_s) begin
                        edge_fall_r <= 1'b1;
                        fall_cnt_r  <= sat_inc(fall_cnt_r);
                        event_ts_r  <= conv_idx_r;
                        ho_cnt_r    <= '0;
                        state_r     <= ST_HOLDOFF;
                    end
                end
                ST_HOLDOFF: begin
                    if (ho_cnt_r >= holdoff) begin
                        state_r <= ST_WAIT_REARM;
                    end else if (upd_r) begin
                        ho_cnt_r <= ho_cnt_r + HOLDOFF_W'(1);
                    end
                end
                ST_WAIT_REARM: begin
                    if (upd_r && in_band_s) begin
                        state_r <= ST_ARMED;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign conv       = conv_r;
    assign conv_valid = conv_valid_r;
    assign edge_rise  = edge_rise_r;
    assign edge_fall  = edge_fall_r;
    assign event_ts   = event_ts_r;
    assign rise_count = rise_cnt_r;
    assign fall_count = fall_cnt_r;
    assign det_state  = state_r;

endmodule
